// File: rtl/trs80_kbd_pkg.sv
// Shared types and constants for the TRS-80 Model III keyboard matrix bridge:
// matrix positions, release-queue entries and the hold/drain FSM state.
package trs80_kbd_pkg;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    typedef struct packed {
        logic       dead;
        logic [2:0] row;
        logic [2:0] col;
    } rq_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } kbd_state_t;

    localparam logic [2:0] ROW_AT    = 3'd0;
    localparam logic [2:0] ROW_H     = 3'd1;
    localparam logic [2:0] ROW_P     = 3'd2;
    localparam logic [2:0] ROW_X     = 3'd3;
    localparam logic [2:0] ROW_DIG0  = 3'd4;
    localparam logic [2:0] ROW_DIG8  = 3'd5;
    localparam logic [2:0] ROW_CTRL  = 3'd6;
    localparam logic [2:0] ROW_SHIFT = 3'd7;

    localparam logic [2:0] COL_0 = 3'd0;
    localparam logic [2:0] COL_1 = 3'd1;
    localparam logic [2:0] COL_2 = 3'd2;
    localparam logic [2:0] COL_3 = 3'd3;
    localparam logic [2:0] COL_4 = 3'd4;
    localparam logic [2:0] COL_5 = 3'd5;
    localparam logic [2:0] COL_6 = 3'd6;
    localparam logic [2:0] COL_7 = 3'd7;

    localparam key_pos_t KEY_NONE   = '{valid: 1'b0, row: 3'd0, col: 3'd0};
    localparam key_pos_t KEY_ENTER  = '{valid: 1'b1, row: ROW_CTRL,  col: COL_0};
    localparam key_pos_t KEY_CLEAR  = '{valid: 1'b1, row: ROW_CTRL,  col: COL_1};
    localparam key_pos_t KEY_BREAK  = '{valid: 1'b1, row: ROW_CTRL,  col: COL_2};
    localparam key_pos_t KEY_UP     = '{valid: 1'b1, row: ROW_CTRL,  col: COL_3};
    localparam key_pos_t KEY_DOWN   = '{valid: 1'b1, row: ROW_CTRL,  col: COL_4};
    localparam key_pos_t KEY_LEFT   = '{valid: 1'b1, row: ROW_CTRL,  col: COL_5};
    localparam key_pos_t KEY_RIGHT  = '{valid: 1'b1, row: ROW_CTRL,  col: COL_6};
    localparam key_pos_t KEY_SPACE  = '{valid: 1'b1, row: ROW_CTRL,  col: COL_7};
    localparam key_pos_t KEY_LSHIFT = '{valid: 1'b1, row: ROW_SHIFT, col: COL_0};
    localparam key_pos_t KEY_RSHIFT = '{valid: 1'b1, row: ROW_SHIFT, col: COL_1};

    function automatic key_pos_t key_at(input logic [2:0] row, input logic [2:0] col);
        key_pos_t pos;
        pos.valid = 1'b1;
        pos.row   = row;
        pos.col   = col;
        return pos;
    endfunction

endpackage

// File: rtl/ps2_to_trs80_map.sv
// Combinational PS/2 set-2 {extended, scancode} to TRS-80 matrix position lookup.
// Anything not listed (including E0-prefixed keypad duplicates) comes back invalid.
module ps2_to_trs80_map
    import trs80_kbd_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output key_pos_t   pos_o
);

    // Scancode table; '[' stands in for '@' and the apostrophe key for ':'
    always_comb begin
        pos_o = KEY_NONE;
        case ({ext_i, code_i})
            9'h054: pos_o = key_at(ROW_AT, COL_0);
            9'h01C: pos_o = key_at(ROW_AT, COL_1);
            9'h032: pos_o = key_at(ROW_AT, COL_2);
            9'h021: pos_o = key_at(ROW_AT, COL_3);
            9'h023: pos_o = key_at(ROW_AT, COL_4);
            9'h024: pos_o = key_at(ROW_AT, COL_5);
            9'h02B: pos_o = key_at(ROW_AT, COL_6);
            9'h034: pos_o = key_at(ROW_AT, COL_7);
            9'h033: pos_o = key_at(ROW_H, COL_0);
            9'h043: pos_o = key_at(ROW_H, COL_1);
            9'h03B: pos_o = key_at(ROW_H, COL_2);
            9'h042: pos_o = key_at(ROW_H, COL_3);
            9'h04B: pos_o = key_at(ROW_H, COL_4);
            9'h03A: pos_o = key_at(ROW_H, COL_5);
            9'h031: pos_o = key_at(ROW_H, COL_6);
            9'h044: pos_o = key_at(ROW_H, COL_7);
            9'h04D: pos_o = key_at(ROW_P, COL_0);
            9'h015: pos_o = key_at(ROW_P, COL_1);
            9'h02D: pos_o = key_at(ROW_P, COL_2);
            9'h01B: pos_o = key_at(ROW_P, COL_3);
            9'h02C: pos_o = key_at(ROW_P, COL_4);
            9'h03C: pos_o = key_at(ROW_P, COL_5);
            9'h02A: pos_o = key_at(ROW_P, COL_6);
            9'h01D: pos_o = key_at(ROW_P, COL_7);
            9'h022: pos_o = key_at(ROW_X, COL_0);
            9'h035: pos_o = key_at(ROW_X, COL_1);
            9'h01A: pos_o = key_at(ROW_X, COL_2);
            9'h045: pos_o = key_at(ROW_DIG0, COL_0);
            9'h016: pos_o = key_at(ROW_DIG0, COL_1);
            9'h01E: pos_o = key_at(ROW_DIG0, COL_2);
            9'h026: pos_o = key_at(ROW_DIG0, COL_3);
            9'h025: pos_o = key_at(ROW_DIG0, COL_4);
            9'h02E: pos_o = key_at(ROW_DIG0, COL_5);
            9'h036: pos_o = key_at(ROW_DIG0, COL_6);
            9'h03D: pos_o = key_at(ROW_DIG0, COL_7);
            9'h03E: pos_o = key_at(ROW_DIG8, COL_0);
            9'h046: pos_o = key_at(ROW_DIG8, COL_1);
            9'h052: pos_o = key_at(ROW_DIG8, COL_2);
            9'h04C: pos_o = key_at(ROW_DIG8, COL_3);
            9'h041: pos_o = key_at(ROW_DIG8, COL_4);
            9'h04E: pos_o = key_at(ROW_DIG8, COL_5);
            9'h049: pos_o = key_at(ROW_DIG8, COL_6);
            9'h04A: pos_o = key_at(ROW_DIG8, COL_7);
            9'h05A: pos_o = KEY_ENTER;
            9'h15A: pos_o = KEY_ENTER;
            9'h16C: pos_o = KEY_CLEAR;
            9'h076: pos_o = KEY_BREAK;
            9'h175: pos_o = KEY_UP;
            9'h172: pos_o = KEY_DOWN;
            9'h16B: pos_o = KEY_LEFT;
            9'h174: pos_o = KEY_RIGHT;
            9'h029: pos_o = KEY_SPACE;
            9'h012: pos_o = KEY_LSHIFT;
            9'h059: pos_o = KEY_RSHIFT;
            default: pos_o = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/trs80_key_matrix.sv
// PS/2 key events to TRS-80 Model III 8x8 keyboard matrix, with a minimum hold window
// so short taps survive the ROM's scan; releases inside the window are deferred in a queue.
module trs80_key_matrix
    import trs80_kbd_pkg::*;
#(
    parameter int CLK_KHZ  = 20000,
    parameter int HOLD_MS  = 20,
    parameter int RQ_DEPTH = 4
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       key_strobe_i,
    input  logic       key_pressed_i,
    input  logic       key_extended_i,
    input  logic [7:0] key_code_i,
    input  logic [7:0] rows_i,
    output logic [7:0] cols_o,
    output logic       busy_o
);

    localparam int AW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [24:0] HOLD_LOAD = 25'(CLK_KHZ * HOLD_MS - 1);

    key_pos_t        map_pos_s;
    logic            ev_press_s;
    logic            ev_release_s;
    logic            release_now_s;
    logic            push_s;
    logic            pop_s;
    logic            rq_full_s;
    logic            rq_empty_s;
    rq_entry_t       pop_entry_s;

    logic [7:0][7:0] matrix_q, matrix_d;
    logic [24:0]     hold_q, hold_d;
    rq_entry_t       rq_q [RQ_DEPTH];
    rq_entry_t       rq_d [RQ_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    kbd_state_t      state_q, state_d;
    logic [7:0]      cols_q, cols_d;
    logic            busy_q, busy_d;

    ps2_to_trs80_map u_map (
        .ext_i  (key_extended_i),
        .code_i (key_code_i),
        .pos_o  (map_pos_s)
    );

    assign ev_press_s    = key_strobe_i & key_pressed_i & map_pos_s.valid;
    assign ev_release_s  = key_strobe_i & ~key_pressed_i & map_pos_s.valid;
    assign rq_full_s     = (count_q == CW'(RQ_DEPTH));
    assign rq_empty_s    = (count_q == {CW{1'b0}});
    // A press during drain pauses popping so the remaining entries wait for the new window.
    assign pop_s         = (state_q == ST_DRAIN) & ~rq_empty_s & ~ev_press_s;
    assign release_now_s = ev_release_s & (((hold_q == 25'd0) & rq_empty_s) | rq_full_s);
    assign push_s        = ev_release_s & ~release_now_s;
    assign pop_entry_s   = rq_q[rd_ptr_q];

    // Matrix, hold counter and release-queue next state
    always_comb begin
        matrix_d = matrix_q;
        rq_d     = rq_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(pop_s);

        if (ev_press_s) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != 25'd0) begin
            hold_d = hold_q - 25'd1;
        end else begin
            hold_d = hold_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (!pop_entry_s.dead) begin
                matrix_d[pop_entry_s.row][pop_entry_s.col] = 1'b0;
            end else begin
                matrix_d = matrix_d;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // The strobe is applied after the pop so it has the final word on its own key.
        if (ev_press_s) begin
            matrix_d[map_pos_s.row][map_pos_s.col] = 1'b1;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                if ((rq_q[i].row == map_pos_s.row) && (rq_q[i].col == map_pos_s.col)) begin
                    rq_d[i].dead = 1'b1;
                end else begin
                    rq_d[i].dead = rq_q[i].dead;
                end
            end
        end else if (release_now_s) begin
            matrix_d[map_pos_s.row][map_pos_s.col] = 1'b0;
        end else if (push_s) begin
            rq_d[wr_ptr_q] = '{dead: 1'b0, row: map_pos_s.row, col: map_pos_s.col};
            wr_ptr_d       = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Hold/drain sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hold_d != 25'd0) begin
                    state_d = ST_HOLD;
                end else if (count_d != {CW{1'b0}}) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_d != 25'd0) begin
                    state_d = ST_HOLD;
                end else if (count_d != {CW{1'b0}}) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (ev_press_s) begin
                    state_d = ST_HOLD;
                end else if (count_d != {CW{1'b0}}) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Column readback and busy flag
    always_comb begin
        cols_d = 8'h00;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                cols_d[c] = cols_d[c] | (rows_i[r] & matrix_q[r][c]);
            end
        end
        busy_d = (hold_d != 25'd0) | (count_d != {CW{1'b0}});
    end

    // State registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            matrix_q <= '0;
            hold_q   <= 25'd0;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            state_q  <= ST_IDLE;
            cols_q   <= 8'h00;
            busy_q   <= 1'b0;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq_q[i] <= '0;
            end
        end else begin
            matrix_q <= matrix_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cols_q   <= cols_d;
            busy_q   <= busy_d;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq_q[i] <= rq_d[i];
            end
        end
    end

    assign cols_o = cols_q;
    assign busy_o = busy_q;

endmodule
